auto_cmd12_ctrl: RTL and testbench
==================================

# auto_cmd12_ctrl

Data-transfer sequencer that sits directly upstream of the command path. It tracks the block count of a multi-block transfer and decides when the transfer ends. When Auto CMD12 is enabled, it produces the single-cycle CMD12 request that the command path latches and issues. It also waits for the CMD12 response and reports transfer-complete and Auto-CMD12 error events to the register file.

## Interface
Parameters:
- BLK_CNT_W, 16, width of the block counter (matches the block count register).
- RSP_TIMEOUT, 128, cycles to wait for the CMD12 response before flagging an error.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - clk_i  in  1  clock.
  - rst_i  in  1  reset; asynchronous, active-high.
- Transfer setup:
  - xfer_start_i  in  1  pulse: a data command was accepted by the command path.
  - multi_block_i  in  1  transfer mode, multi-block select.
  - block_count_en_i  in  1  transfer mode, block count enable.
  - auto_cmd12_en_i  in  1  transfer mode, Auto CMD12 enable.
  - block_count_i  in  BLK_CNT_W  block count register value, sampled on xfer_start_i.
- Data-path events:
  - block_done_i  in  1  pulse: one block moved with good CRC.
  - data_err_i  in  1  pulse: data CRC, end-bit or timeout error.
  - abort_i  in  1  pulse: software stop request.
- Command-path handshake:
  - cmd_idle_i  in  1  command path is ready and not inhibited.
  - cmd12_rsp_done_i  in  1  pulse: CMD12 response received.
  - cmd12_rsp_err_i  in  1  qualifies cmd12_rsp_done_i: response had a CRC, index or end-bit error.
- Outputs:
  - request_cmd12_o  out  1  one-cycle CMD12 request to the command path.
  - block_count_o  out  BLK_CNT_W  decremented count (hw2reg d).
  - block_count_de_o  out  1  write enable for block_count_o.
  - xfer_active_o  out  1  a transfer is in progress (drives the data-inhibit status).
  - xfer_complete_o  out  1  one-cycle transfer-complete interrupt pulse.
  - auto_cmd12_err_o  out  1  one-cycle Auto CMD12 error pulse.

## Operation
- States: IDLE, XFER, WAIT_CMD, ISSUE, WAIT_RSP, FINISH.
- IDLE:
  - On xfer_start_i, load cnt (BLK_CNT_W bits).
  - cnt = 1 if !multi_block_i; otherwise cnt = block_count_i.
  - Next state XFER, except when block_count_en_i & multi_block_i & block_count_i == 0, which goes to FINISH (empty transfer).
- XFER:
  - On block_done_i with block_count_en_i (or single-block): cnt decrements. block_count_o = cnt-1 and block_count_de_o = 1 in the same cycle.
  - Last block (cnt == 1):
    - multi_block_i & auto_cmd12_en_i: go to WAIT_CMD.
    - Otherwise: go to FINISH.
  - block_count_en_i = 0: unbounded transfer. Only abort_i or data_err_i ends it.
  - On abort_i: go to WAIT_CMD if multi_block_i & auto_cmd12_en_i, otherwise FINISH.
  - On data_err_i:
    - Set err_q (suppresses xfer_complete_o).
    - Go to WAIT_CMD if multi_block_i & auto_cmd12_en_i, so the card is stopped.
    - Otherwise go to IDLE.
- WAIT_CMD: hold until cmd_idle_i, then go to ISSUE.
- ISSUE:
  - request_cmd12_o = 1 for exactly one cycle.
  - Clear the timeout counter.
  - Go to WAIT_RSP.
- WAIT_RSP: the timeout counter increments every cycle.
  - On cmd12_rsp_done_i:
    - If cmd12_rsp_err_i: pulse auto_cmd12_err_o and go to IDLE.
    - Otherwise: go to FINISH if !err_q, IDLE if err_q.
  - On counter == RSP_TIMEOUT-1 without a response: pulse auto_cmd12_err_o and go to IDLE.
- FINISH: xfer_complete_o = 1 for one cycle, then go to IDLE. err_q is cleared on entry to IDLE.
- xfer_active_o = 1 in every state except IDLE.
- Simultaneous events and boundary cases:
  - data_err_i together with block_done_i: the error wins and cnt is not decremented.
  - abort_i together with block_done_i: the decrement happens and the abort is taken.
  - abort_i outside XFER is ignored. An issued CMD12 always runs to response or timeout.
  - xfer_start_i outside IDLE is ignored.
  - cnt never wraps: block_done_i with cnt == 0 is ignored.
  - If cmd12_rsp_done_i and the timeout coincide, the response wins.

## Timing
- Reset (rst_i high, any state): state goes to IDLE, and cnt, err_q and the timeout counter are cleared. All outputs are 0, including block_count_o.
- State is registered. request_cmd12_o, xfer_active_o and xfer_complete_o are decoded from the registered state (Moore). auto_cmd12_err_o is registered.
- block_count_de_o and block_count_o are combinational from block_done_i and cnt, so there is zero latency to the register file.
- Latencies:
  - Last block_done_i (WAIT_CMD path) to request_cmd12_o: 2 cycles minimum (WAIT_CMD, then ISSUE, when cmd_idle_i is already high).
  - Last block_done_i (FINISH path, non-Auto-CMD12) to xfer_complete_o: 1 cycle.
  - cmd12_rsp_done_i to xfer_complete_o: 1 cycle.
- The command path treats request_cmd12_o as sticky, so a one-cycle pulse is sufficient.

## Structure
- Shared package holds:
  - the state enum auto_cmd12_state_e;
  - the localparam CMD12_INDEX = 6'd12.
- One sub-module: a generic up/down counter with load and clear. It is instantiated twice, once for cnt (down, load) and once for the response timeout (up, clear).
- Everything else is one always_comb next-state/output block plus flops.

## Test plan
- Multi-block, count = 3, auto_cmd12_en: three block_done_i pulses.
  - block_count_de_o pulses with values 2, 1, 0.
  - request_cmd12_o pulses once, 2 cycles after the third pulse.
  - cmd12_rsp_done_i leads to xfer_complete_o 1 cycle later.
- Single-block, no auto: one block_done_i gives xfer_complete_o the next cycle, with no request_cmd12_o.
- Multi-block, count = 5, data_err_i after block 2:
  - block_count_o stays at 3.
  - CMD12 is issued and its response arrives.
  - No xfer_complete_o pulse; state returns to IDLE.
- cmd_idle_i held low 10 cycles after the last block: request_cmd12_o is delayed until 1 cycle after cmd_idle_i rises.
- No CMD12 response for RSP_TIMEOUT cycles: auto_cmd12_err_o pulses once, then IDLE. Separately, a response with cmd12_rsp_err_i=1 gives auto_cmd12_err_o and no xfer_complete_o.
- rst_i asserted in WAIT_RSP:
  - All outputs go to 0 asynchronously.
  - A later xfer_start_i with count 0 (block_count_en_i=1) gives an immediate FINISH and one xfer_complete_o pulse.

Source files
------------

// File: rtl/auto_cmd12_ctrl_pkg.sv
// Shared types and constants for the Auto CMD12 transfer sequencer.
package auto_cmd12_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_XFER,
        ST_WAIT_CMD,
        ST_ISSUE,
        ST_WAIT_RSP,
        ST_FINISH
    } auto_cmd12_state_e;

    localparam logic [5:0] CMD12_INDEX = 6'd12;

endpackage

// File: rtl/auto_cmd12_ctrl_counter.sv
// Generic up/down counter with synchronous clear and load (clear > load > count).
module auto_cmd12_ctrl_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         up,
    input  logic         down,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (up && !down) begin
            count <= count + W'(1);
        end else if (down && !up) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/auto_cmd12_ctrl.sv
// Multi-block transfer sequencer: tracks block count, issues Auto CMD12 and
// reports transfer-complete / Auto CMD12 error events.
//
// state    | meaning
// IDLE     | no transfer; waits for xfer_start_i
// XFER     | data blocks moving; counts block_done_i
// WAIT_CMD | transfer ended, waiting for command path to go idle
// ISSUE    | one-cycle CMD12 request
// WAIT_RSP | waiting for CMD12 response or timeout
// FINISH   | one-cycle transfer-complete pulse
module auto_cmd12_ctrl
    import auto_cmd12_ctrl_pkg::*;
#(
    parameter int BLK_CNT_W   = 16,
    parameter int RSP_TIMEOUT = 128
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 xfer_start_i,
    input  logic                 multi_block_i,
    input  logic                 block_count_en_i,
    input  logic                 auto_cmd12_en_i,
    input  logic [BLK_CNT_W-1:0] block_count_i,
    input  logic                 block_done_i,
    input  logic                 data_err_i,
    input  logic                 abort_i,
    input  logic                 cmd_idle_i,
    input  logic                 cmd12_rsp_done_i,
    input  logic                 cmd12_rsp_err_i,
    output logic                 request_cmd12_o,
    output logic [BLK_CNT_W-1:0] block_count_o,
    output logic                 block_count_de_o,
    output logic                 xfer_active_o,
    output logic                 xfer_complete_o,
    output logic                 auto_cmd12_err_o
);

    localparam int TMO_W = $clog2(RSP_TIMEOUT) + 1;

    auto_cmd12_state_e state_q, state_d;

    logic [BLK_CNT_W-1:0] cnt;
    logic [BLK_CNT_W-1:0] cnt_load_val;
    logic                 cnt_load;
    logic                 cnt_dec;
    logic [TMO_W-1:0]     tmo;
    logic                 tmo_clr;
    logic                 tmo_inc;
    logic                 err_q;
    logic                 err_set;
    logic                 a12_err_d;
    logic                 auto_stop;

    auto_cmd12_ctrl_counter #(.W(BLK_CNT_W)) u_blk_cnt (
        .clk      (clk_i),
        .rst      (rst_i),
        .clr      (1'b0),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .up       (1'b0),
        .down     (cnt_dec),
        .count    (cnt)
    );

    auto_cmd12_ctrl_counter #(.W(TMO_W)) u_rsp_tmo (
        .clk      (clk_i),
        .rst      (rst_i),
        .clr      (tmo_clr),
        .load     (1'b0),
        .load_val ('0),
        .up       (tmo_inc),
        .down     (1'b0),
        .count    (tmo)
    );

    assign auto_stop = multi_block_i & auto_cmd12_en_i;

    // A data error in the same cycle as block_done_i means the block was bad.
    assign cnt_dec = (state_q == ST_XFER) && block_done_i && !data_err_i &&
                     (cnt != '0) && (block_count_en_i || !multi_block_i);

    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = multi_block_i ? block_count_i : BLK_CNT_W'(1);
        tmo_clr      = 1'b0;
        tmo_inc      = 1'b0;
        err_set      = 1'b0;
        a12_err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (xfer_start_i) begin
                    cnt_load = 1'b1;
                    if (block_count_en_i && multi_block_i && (block_count_i == '0)) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_XFER;
                    end
                end
            end
            ST_XFER: begin
                if (data_err_i) begin
                    err_set = 1'b1;
                    state_d = auto_stop ? ST_WAIT_CMD : ST_IDLE;
                end else if ((cnt_dec && (cnt == BLK_CNT_W'(1))) || abort_i) begin
                    state_d = auto_stop ? ST_WAIT_CMD : ST_FINISH;
                end
            end
            ST_WAIT_CMD: begin
                if (cmd_idle_i) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tmo_clr = 1'b1;
                state_d = ST_WAIT_RSP;
            end
            ST_WAIT_RSP: begin
                tmo_inc = 1'b1;
                // A response arriving on the timeout cycle still counts.
                if (cmd12_rsp_done_i) begin
                    if (cmd12_rsp_err_i) begin
                        a12_err_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = err_q ? ST_IDLE : ST_FINISH;
                    end
                end else if (tmo == TMO_W'(RSP_TIMEOUT - 1)) begin
                    a12_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q          <= ST_IDLE;
            err_q            <= 1'b0;
            auto_cmd12_err_o <= 1'b0;
        end else begin
            state_q          <= state_d;
            auto_cmd12_err_o <= a12_err_d;
            if (state_d == ST_IDLE) begin
                err_q <= 1'b0;
            end else if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    assign block_count_de_o = cnt_dec;
    assign block_count_o    = cnt_dec ? (cnt - BLK_CNT_W'(1)) : cnt;
    assign request_cmd12_o  = (state_q == ST_ISSUE);
    assign xfer_complete_o  = (state_q == ST_FINISH);
    assign xfer_active_o    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_auto_cmd12_ctrl.sv
// Directed self-checking bench for auto_cmd12_ctrl.
module tb_auto_cmd12_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        xfer_start_i;
    logic        multi_block_i;
    logic        block_count_en_i;
    logic        auto_cmd12_en_i;
    logic [15:0] block_count_i;
    logic        block_done_i;
    logic        data_err_i;
    logic        abort_i;
    logic        cmd_idle_i;
    logic        cmd12_rsp_done_i;
    logic        cmd12_rsp_err_i;
    logic        request_cmd12_o;
    logic [15:0] block_count_o;
    logic        block_count_de_o;
    logic        xfer_active_o;
    logic        xfer_complete_o;
    logic        auto_cmd12_err_o;

    int n_chk = 0;
    int n_bad = 0;

    auto_cmd12_ctrl #(.BLK_CNT_W(16), .RSP_TIMEOUT(128)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .xfer_start_i     (xfer_start_i),
        .multi_block_i    (multi_block_i),
        .block_count_en_i (block_count_en_i),
        .auto_cmd12_en_i  (auto_cmd12_en_i),
        .block_count_i    (block_count_i),
        .block_done_i     (block_done_i),
        .data_err_i       (data_err_i),
        .abort_i          (abort_i),
        .cmd_idle_i       (cmd_idle_i),
        .cmd12_rsp_done_i (cmd12_rsp_done_i),
        .cmd12_rsp_err_i  (cmd12_rsp_err_i),
        .request_cmd12_o  (request_cmd12_o),
        .block_count_o    (block_count_o),
        .block_count_de_o (block_count_de_o),
        .xfer_active_o    (xfer_active_o),
        .xfer_complete_o  (xfer_complete_o),
        .auto_cmd12_err_o (auto_cmd12_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start(input logic m, input logic bce, input logic a, input logic [15:0] n);
        multi_block_i    = m;
        block_count_en_i = bce;
        auto_cmd12_en_i  = a;
        block_count_i    = n;
        xfer_start_i     = 1'b1;
        step();
        xfer_start_i     = 1'b0;
    endtask

    // single-block-count auto transfer, leaves the DUT in its first WAIT_RSP cycle
    task automatic to_wait_rsp();
        start(1'b1, 1'b1, 1'b1, 16'd1);
        block_done_i = 1'b1;
        step();
        block_done_i = 1'b0;
        step();
        step();
    endtask

    initial begin
        rst_i = 1'b1;
        xfer_start_i = 0; multi_block_i = 0; block_count_en_i = 0; auto_cmd12_en_i = 0;
        block_count_i = 0; block_done_i = 0; data_err_i = 0; abort_i = 0;
        cmd_idle_i = 1; cmd12_rsp_done_i = 0; cmd12_rsp_err_i = 0;
        #12;
        chk("rst_outs", {request_cmd12_o, block_count_de_o, xfer_active_o, xfer_complete_o, auto_cmd12_err_o}, 0);
        chk("rst_bco", block_count_o, 0);
        step();
        rst_i = 1'b0;
        step();

        // multi-block, count 3, auto CMD12
        start(1'b1, 1'b1, 1'b1, 16'd3);
        chk("t1_active", xfer_active_o, 1);
        block_done_i = 1'b1; #1;
        chk("t1_de0", block_count_de_o, 1);
        chk("t1_bco0", block_count_o, 2);
        step();
        block_done_i = 1'b0; #1;
        chk("t1_de_idle", block_count_de_o, 0);
        xfer_start_i = 1'b1; block_count_i = 16'd9;
        step();
        xfer_start_i = 1'b0;
        block_done_i = 1'b1; #1;
        chk("t1_bco1", block_count_o, 1);
        step();
        chk("t1_bco2", block_count_o, 0);
        chk("t1_de2", block_count_de_o, 1);
        step();
        block_done_i = 1'b0; #1;
        chk("t1_req_wait", request_cmd12_o, 0);
        step();
        chk("t1_req", request_cmd12_o, 1);
        step();
        chk("t1_req_end", request_cmd12_o, 0);
        cmd12_rsp_done_i = 1'b1;
        step();
        cmd12_rsp_done_i = 1'b0;
        chk("t1_cmpl", xfer_complete_o, 1);
        step();
        chk("t1_cmpl_end", xfer_complete_o, 0);
        chk("t1_idle", xfer_active_o, 0);

        // single block, no auto
        start(1'b0, 1'b0, 1'b0, 16'd7);
        block_done_i = 1'b1; #1;
        chk("t2_de", block_count_de_o, 1);
        chk("t2_bco", block_count_o, 0);
        step();
        block_done_i = 1'b0;
        chk("t2_cmpl", xfer_complete_o, 1);
        chk("t2_noreq", request_cmd12_o, 0);
        step();
        chk("t2_idle", xfer_active_o, 0);

        // count 5, data error coincident with third block
        start(1'b1, 1'b1, 1'b1, 16'd5);
        block_done_i = 1'b1;
        step();
        step();
        data_err_i = 1'b1; #1;
        chk("t3_err_de", block_count_de_o, 0);
        chk("t3_err_bco", block_count_o, 3);
        step();
        block_done_i = 1'b0; data_err_i = 1'b0; #1;
        chk("t3_bco_hold", block_count_o, 3);
        step();
        chk("t3_req", request_cmd12_o, 1);
        step();
        cmd12_rsp_done_i = 1'b1;
        step();
        cmd12_rsp_done_i = 1'b0;
        chk("t3_nocmpl", xfer_complete_o, 0);
        chk("t3_idle", xfer_active_o, 0);
        chk("t3_noerr", auto_cmd12_err_o, 0);

        // command path busy for 10 cycles after last block
        cmd_idle_i = 1'b0;
        start(1'b1, 1'b1, 1'b1, 16'd1);
        block_done_i = 1'b1;
        step();
        block_done_i = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("t4_req_held", request_cmd12_o, 0);
        cmd_idle_i = 1'b1;
        step();
        chk("t4_req", request_cmd12_o, 1);
        step();
        cmd12_rsp_done_i = 1'b1;
        step();
        cmd12_rsp_done_i = 1'b0;
        chk("t4_cmpl", xfer_complete_o, 1);
        step();

        // response timeout
        to_wait_rsp();
        for (int i = 0; i < 127; i++) step();
        chk("t5_active_tmo", xfer_active_o, 1);
        chk("t5_noerr_yet", auto_cmd12_err_o, 0);
        step();
        chk("t5_err", auto_cmd12_err_o, 1);
        chk("t5_idle", xfer_active_o, 0);
        step();
        chk("t5_err_end", auto_cmd12_err_o, 0);

        // response on the timeout cycle wins
        to_wait_rsp();
        for (int i = 0; i < 127; i++) step();
        cmd12_rsp_done_i = 1'b1;
        step();
        cmd12_rsp_done_i = 1'b0;
        chk("t5b_cmpl", xfer_complete_o, 1);
        chk("t5b_noerr", auto_cmd12_err_o, 0);
        step();

        // response with error
        to_wait_rsp();
        cmd12_rsp_done_i = 1'b1; cmd12_rsp_err_i = 1'b1;
        step();
        cmd12_rsp_done_i = 1'b0; cmd12_rsp_err_i = 1'b0;
        chk("t6_err", auto_cmd12_err_o, 1);
        chk("t6_nocmpl", xfer_complete_o, 0);
        step();
        chk("t6_nocmpl2", xfer_complete_o, 0);

        // abort with block_done, no auto: decrement then finish
        start(1'b1, 1'b1, 1'b0, 16'd4);
        block_done_i = 1'b1; abort_i = 1'b1; #1;
        chk("t7_de", block_count_de_o, 1);
        chk("t7_bco", block_count_o, 3);
        step();
        block_done_i = 1'b0; abort_i = 1'b0;
        chk("t7_cmpl", xfer_complete_o, 1);
        step();

        // unbounded transfer ended by abort, auto CMD12
        start(1'b1, 1'b0, 1'b1, 16'd2);
        block_done_i = 1'b1; #1;
        chk("t8_no_de", block_count_de_o, 0);
        step();
        step();
        block_done_i = 1'b0;
        chk("t8_still", xfer_active_o, 1);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        step();
        chk("t8_req", request_cmd12_o, 1);
        step();
        cmd12_rsp_done_i = 1'b1;
        step();
        cmd12_rsp_done_i = 1'b0;
        chk("t8_cmpl", xfer_complete_o, 1);
        step();

        // asynchronous reset in WAIT_RSP, then empty transfer
        to_wait_rsp();
        chk("t9_active", xfer_active_o, 1);
        #2 rst_i = 1'b1;
        #1;
        chk("t9_rst_outs", {request_cmd12_o, block_count_de_o, xfer_active_o, xfer_complete_o, auto_cmd12_err_o}, 0);
        chk("t9_rst_bco", block_count_o, 0);
        step();
        rst_i = 1'b0;
        step();
        start(1'b1, 1'b1, 1'b1, 16'd0);
        chk("t9_empty_cmpl", xfer_complete_o, 1);
        chk("t9_empty_noreq", request_cmd12_o, 0);
        step();
        chk("t9_cmpl_end", xfer_complete_o, 0);
        chk("t9_idle", xfer_active_o, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
